// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: turns raw push-buttons into the 4-bit moveState code
// consumed by the snake graphics block. Each button is synchronised,
// debounced and edge-detected; the presses then steer a direction register
// that uses priority resolution and refuses direct reversals.
// Optional pause on the centre button is enabled by defining MOVE_PAUSE_EN.
module snake_move_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [3:0] moveState,
    output logic       paused,
    output logic       turn_pulse
);

`ifdef MOVE_PAUSE_EN
    localparam int unsigned NUM_BTN = 5;
`else
    localparam int unsigned NUM_BTN = 4;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        DIR_UP    = 4'd0,
        DIR_DOWN  = 4'd1,
        DIR_LEFT  = 4'd2,
        DIR_RIGHT = 4'd3,
        DIR_STOP  = 4'd4
    } dir_t;

    // Button bit order: 0=up, 1=down, 2=left, 3=right, 4=centre (pause build only)
    logic [NUM_BTN-1:0] btnRaw;
    logic [NUM_BTN-1:0] s1;
    logic [NUM_BTN-1:0] s2;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] stableQ;
    logic [NUM_BTN-1:0] press;
    logic [CNT_W-1:0]   cnt [NUM_BTN];

    dir_t dirQ;
    dir_t dirN;
    dir_t cand;
    logic candValid;
    logic accept;
    logic pulseQ;
    logic pulseN;

`ifdef MOVE_PAUSE_EN
    dir_t savedQ;
    dir_t savedN;
    logic pausedQ;
    logic pausedN;

    assign btnRaw = {btn_center, btn_right, btn_left, btn_down, btn_up};
`else
    logic unusedCenter;

    assign unusedCenter = btn_center;
    assign btnRaw       = {btn_right, btn_left, btn_down, btn_up};
`endif

    // Synchronise, debounce and remember the previous stable level per button
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            stable  <= '0;
            stableQ <= '0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= btnRaw;
            s2      <= s1;
            stableQ <= stable;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                if (s2[i] != stable[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        stable[i] <= s2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Rising edge of the debounced level; releases are ignored
    assign press = stable & ~stableQ;

    // Pick the single highest-priority direction press and judge it
    always_comb begin
        cand      = DIR_STOP;
        candValid = 1'b0;
        if (press[0]) begin
            cand      = DIR_UP;
            candValid = 1'b1;
        end else if (press[1]) begin
            cand      = DIR_DOWN;
            candValid = 1'b1;
        end else if (press[2]) begin
            cand      = DIR_LEFT;
            candValid = 1'b1;
        end else if (press[3]) begin
            cand      = DIR_RIGHT;
            candValid = 1'b1;
        end
        // Opposites differ only in bit 0; a stopped snake (4) never matches
        accept = candValid && (cand != dirQ) && (dirQ != (cand ^ 4'd1));
    end

    // Next direction, pause state and turn strobe
    always_comb begin
        dirN   = dirQ;
        pulseN = 1'b0;
`ifdef MOVE_PAUSE_EN
        savedN  = savedQ;
        pausedN = pausedQ;
        if (press[4]) begin
            if (!pausedQ) begin
                savedN  = dirQ;
                dirN    = DIR_STOP;
                pausedN = 1'b1;
                pulseN  = (dirQ != DIR_STOP);
            end else begin
                dirN    = savedQ;
                pausedN = 1'b0;
                pulseN  = (savedQ != dirQ);
            end
        end else if (!pausedQ && accept) begin
            dirN   = cand;
            pulseN = 1'b1;
        end
`else
        if (accept) begin
            dirN   = cand;
            pulseN = 1'b1;
        end
`endif
    end

    // Direction / pause state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dirQ    <= DIR_STOP;
            pulseQ  <= 1'b0;
`ifdef MOVE_PAUSE_EN
            savedQ  <= DIR_STOP;
            pausedQ <= 1'b0;
`endif
        end else begin
            dirQ    <= dirN;
            pulseQ  <= pulseN;
`ifdef MOVE_PAUSE_EN
            savedQ  <= savedN;
            pausedQ <= pausedN;
`endif
        end
    end

    assign moveState  = dirQ;
    assign turn_pulse = pulseQ;
`ifdef MOVE_PAUSE_EN
    assign paused     = pausedQ;
`else
    assign paused     = 1'b0;
`endif

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Testbench for snake_move_ctrl with a short debounce (4 cycles).
// Expectations for the centre button follow MOVE_PAUSE_EN.
module tb_snake_move_ctrl;

    localparam int unsigned DEB    = 4;
    localparam int unsigned HOLD   = 8;
    localparam int unsigned SETTLE = 12;

    localparam logic [4:0] UP = 5'b00001;
    localparam logic [4:0] DN = 5'b00010;
    localparam logic [4:0] LT = 5'b00100;
    localparam logic [4:0] RT = 5'b01000;
    localparam logic [4:0] CT = 5'b10000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_up, btn_down, btn_left, btn_right, btn_center;
    logic [3:0] moveState;
    logic       paused;
    logic       turn_pulse;

    typedef struct {
        logic [4:0]  mask;
        int unsigned hold;
        logic [3:0]  expMs;
        logic        expPaused;
        int unsigned expPulses;
    } vec_t;

    vec_t part1[$];
    vec_t part2[$];
    vec_t sbq[$];

    int unsigned nVec = 0;
    int unsigned nErr = 0;
    int unsigned pulseCnt = 0;
    bit          sawIllegal = 1'b0;

    snake_move_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_center (btn_center),
        .moveState  (moveState),
        .paused     (paused),
        .turn_pulse (turn_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [4:0] m, input int unsigned h,
                                input logic [3:0] ms, input logic p,
                                input int unsigned np);
        vec_t v;
        v.mask = m; v.hold = h; v.expMs = ms; v.expPaused = p; v.expPulses = np;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (turn_pulse) pulseCnt++;
        if (moveState > 4'd4) sawIllegal = 1'b1;
    endtask

    task automatic setBtns(input logic [4:0] m);
        btn_up     = m[0];
        btn_down   = m[1];
        btn_left   = m[2];
        btn_right  = m[3];
        btn_center = m[4];
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        nVec++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic doReset(input string tag, input int unsigned n);
        reset_n = 1'b0;
        setBtns('0);
        repeat (n) tick();
        check({tag, " reset moveState"}, 32'(moveState), 4);
        check({tag, " reset paused"}, 32'(paused), 0);
        check({tag, " reset turn_pulse"}, 32'(turn_pulse), 0);
        reset_n = 1'b1;
    endtask

    task automatic popCheck(input string tag);
        vec_t e;
        if (sbq.size() == 0) begin
            check({tag, " scoreboard empty"}, 1, 0);
            return;
        end
        e = sbq.pop_front();
        check({tag, " moveState"}, 32'(moveState), 32'(e.expMs));
        check({tag, " paused"}, 32'(paused), 32'(e.expPaused));
        check({tag, " pulses"}, pulseCnt, e.expPulses);
    endtask

    task automatic applyVec(input vec_t v, input string tag);
        sbq.push_back(v);
        pulseCnt = 0;
        setBtns(v.mask);
        repeat (v.hold) tick();
        setBtns('0);
        repeat (SETTLE) tick();
        popCheck(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        setBtns('0);

        // Starts moving right: reversal, glitch, turn, same-direction
        part1.push_back(mk(LT, HOLD, 4'd3, 1'b0, 0));
        part1.push_back(mk(UP, 3,    4'd3, 1'b0, 0));
        part1.push_back(mk(UP, HOLD, 4'd0, 1'b0, 1));
        part1.push_back(mk(DN, HOLD, 4'd0, 1'b0, 0));
        part1.push_back(mk(UP, HOLD, 4'd0, 1'b0, 0));
        part1.push_back(mk(RT, HOLD, 4'd3, 1'b0, 1));

        // Starts stopped: simultaneous presses, then pause
        part2.push_back(mk(LT | DN, HOLD, 4'd1, 1'b0, 1));
        part2.push_back(mk(UP | LT, HOLD, 4'd1, 1'b0, 0));
        part2.push_back(mk(UP | DN, HOLD, 4'd1, 1'b0, 0));
        part2.push_back(mk(LT,      HOLD, 4'd2, 1'b0, 1));
`ifdef MOVE_PAUSE_EN
        part2.push_back(mk(CT, HOLD, 4'd4, 1'b1, 1));
        part2.push_back(mk(RT, HOLD, 4'd4, 1'b1, 0));
        part2.push_back(mk(CT, HOLD, 4'd2, 1'b0, 1));
`else
        part2.push_back(mk(CT, HOLD, 4'd2, 1'b0, 0));
        part2.push_back(mk(RT, HOLD, 4'd2, 1'b0, 0));
        part2.push_back(mk(CT, HOLD, 4'd2, 1'b0, 0));
`endif

        // Exact first-press latency after reset
        doReset("r1", 3);
        setBtns(RT);
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("first edge%0d moveState", e), 32'(moveState), (e >= 7) ? 3 : 4);
            check($sformatf("first edge%0d turn_pulse", e), 32'(turn_pulse), (e == 7) ? 1 : 0);
            if (e == 6) check("first edge6 paused", 32'(paused), 0);
        end
        setBtns('0);
        repeat (SETTLE) tick();

        for (int i = 0; i < part1.size(); i++) applyVec(part1[i], $sformatf("p1v%0d", i));

        doReset("r2", 2);
        for (int i = 0; i < part2.size(); i++) applyVec(part2[i], $sformatf("p2v%0d", i));

        // Reset mid-debounce with up held, then a long hold after release
        doReset("r3", 2);
        setBtns(UP);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        check("midreset moveState", 32'(moveState), 4);
        reset_n = 1'b1;
        pulseCnt = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) check("held edge6 moveState", 32'(moveState), 4);
            if (e == 7) check("held edge7 moveState", 32'(moveState), 0);
        end
        repeat (1000 - 7) tick();
        check("hold1000 pulses", pulseCnt, 1);
        check("hold1000 moveState", 32'(moveState), 0);
        setBtns('0);
        repeat (SETTLE) tick();
        check("release pulses", pulseCnt, 1);
        check("moveState range", 32'(sawIllegal), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
- Upstream stage of the snake graphics block. Converts five raw push-buttons (up/down/left/right/centre) into the 4-bit moveState code the graphics block consumes.
- Per button: 2-FF synchroniser, counter debounce, rising-edge press detection.
- Presses resolve into a direction register, with priority resolution and a no-reversal rule. Optional pause via the centre button.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clocks a synchronised level must differ from the stable level before it is accepted (20 ms at 25 MHz). Legal range 2..2^20-1.
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- btn_up  in  1  raw, asynchronous, active-high
- btn_down  in  1  raw, asynchronous, active-high
- btn_left  in  1  raw, asynchronous, active-high
- btn_right  in  1  raw, asynchronous, active-high
- btn_center  in  1  raw, asynchronous, active-high; pause toggle
- moveState  out  4  0=up, 1=down, 2=left, 3=right, 4=stopped; registered
- paused  out  1  high while paused; registered
- turn_pulse  out  1  one-cycle strobe on every change of moveState; registered

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous, active-low.
  - While reset_n=0 at a rising edge: sync FFs=0, stable levels=0, counters=0, moveState=4, paused=0, turn_pulse=0, saved direction=4.
  - Reset asserted mid-debounce discards the pending count.
  - A button held through reset release is seen as a fresh press after full debounce.
- Synchroniser: raw -> s1 -> s2, one FF each.
- Debounce, per button:
  - If s2 != stable: cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and s2 != stable: stable <= s2, cnt <= 0.
  - If s2 == stable: cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES clocks restarts the count.
- Press detect: press = stable & ~stable_q, where stable_q is stable delayed one clock. Releases generate nothing.
- Latency: count the first edge that samples a new steady raw level as edge 1.
  - stable changes on edge DEBOUNCE_CYCLES+2.
  - moveState/turn_pulse update on edge DEBOUNCE_CYCLES+3. Exact, no jitter.
- Resolution, when several presses occur in the same cycle:
  - Centre (pause) first. Then the highest-priority direction press, order up > down > left > right.
  - Only that single winning press is evaluated; all other presses in the cycle are dropped.
- Direction rules:
  - Stopped (moveState=4): any direction press is accepted.
  - Moving: a press of the opposite direction (0<->1, 2<->3) is rejected with no state change. In a same-cycle up+down press, up wins; it is then rejected if moving down, and down is not tried.
  - A press equal to the current direction is a no-op; turn_pulse stays 0.
  - Accepted change: moveState <= new code, turn_pulse=1 for exactly one cycle.
- moveState never takes values 5..15.
- A held button produces exactly one press.

Optional Feature:
- Macro MOVE_PAUSE_EN.
- Defined:
  - Centre press while not paused: save moveState, moveState <= 4, paused <= 1, turn_pulse=1 (if the saved value != 4).
  - Centre press while paused: restore the saved value, paused <= 0, turn_pulse=1 (if the value changes).
  - While paused, direction presses are ignored.
- Undefined:
  - btn_center path not synthesised; paused tied 0.
  - Centre never affects moveState.

Test Plan:
- Reset/first press: DEBOUNCE_CYCLES=4, reset_n low 3 clocks, then btn_right held high from edge 1 -> moveState=4, paused=0, turn_pulse=0 through edge 6; moveState=3 and turn_pulse=1 on edge 7; turn_pulse=0 on edge 8.
- Glitch rejection: btn_up high 3 clocks then low, DEBOUNCE_CYCLES=4 -> no change, turn_pulse never asserts.
- No reversal: moving right (3), press left -> moveState stays 3. Then press up -> moveState=0 with one turn_pulse. Then press down -> stays 0.
- Simultaneous: stopped, btn_left and btn_down rise on the same edge -> moveState=1. From moving down, up+left same edge -> up wins and is rejected, moveState stays 1.
- Hold/repeat: btn_up held 1000 clocks from stopped -> exactly one turn_pulse, moveState=0.
- Pause (MOVE_PAUSE_EN defined): moving left (2), press centre -> moveState=4, paused=1. Press right -> no change. Press centre -> moveState=2, paused=0. With the macro undefined, the same stimulus -> moveState stays 2, paused=0 throughout.
